// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider and its cycle counter.
package div_pkg;

   localparam int DIV_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift {a,q} left, trial-subtract m, keep or restore.
module div_restore_step #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W:0]   a,
   input  logic [DATA_W-1:0] q,
   input  logic [DATA_W-1:0] m,
   output logic [DATA_W:0]   a_next,
   output logic [DATA_W-1:0] q_next
);

   logic [DATA_W:0] a_sh;
   logic [DATA_W:0] t;

   // a stays below m between steps, so its top bit is always 0 and can be dropped.
   assign a_sh   = {a[DATA_W-1:0], q[DATA_W-1]};
   assign t      = a_sh - {1'b0, m};
   assign a_next = t[DATA_W] ? a_sh : t;
   assign q_next = {q[DATA_W-2:0], ~t[DATA_W]};

endmodule

// File: rtl/seq_div_core.sv
// Unsigned restoring sequential divider, one quotient bit per clock, driving an external cycle counter.
module seq_div_core
   import div_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              cnt_last,
   output logic              cnt_enb,
   output logic              cnt_clr,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              div_by_zero
);

   div_state_e        state, next_state;
   logic [DATA_W:0]   a, a_next;
   logic [DATA_W-1:0] q, q_next, m;
   logic              div_zero_req;

   assign div_zero_req = (divisor == '0);

   div_restore_step #(.DATA_W(DATA_W)) u_step (
      .a      (a),
      .q      (q),
      .m      (m),
      .a_next (a_next),
      .q_next (q_next)
   );

   always_comb begin
      next_state = state;
      ready      = 1'b0;
      done       = 1'b0;
      cnt_enb    = 1'b0;
      cnt_clr    = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               if (!div_zero_req) begin
                  cnt_enb    = 1'b1;
                  cnt_clr    = 1'b1;
                  next_state = RUN;
               end else begin
                  next_state = DONE;
               end
            end
         end
         RUN: begin
            cnt_enb = 1'b1;
            if (cnt_last) next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         a           <= '0;
         q           <= '0;
         m           <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (start && !div_zero_req) begin
                  a <= '0;
                  q <= dividend;
                  m <= divisor;
               end else if (start) begin
                  quotient    <= '1;
                  remainder   <= dividend;
                  div_by_zero <= 1'b1;
               end
            end
            RUN: begin
               a <= a_next;
               q <= q_next;
               // cnt_last marks the edge that performs the final step.
               if (cnt_last) begin
                  quotient    <= q_next;
                  remainder   <= a_next[DATA_W-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
